// File: rtl/cpu_pkg.sv
// Shared fetch constants: halfword queue geometry, Thumb-2 32-bit prefixes, reset PC.
// Latency: none; backpressure: none. Pure declarations.
package cpu_pkg;

    localparam int QUEUE_DEPTH = 4;
    localparam int QPTR_W      = 2;
    localparam int QCNT_W      = 3;

    // Fetch only while the queue would still have room for a full word after this cycle's pops.
    localparam logic [QCNT_W-1:0] REQ_MAX_FILL = QCNT_W'(QUEUE_DEPTH - 2);

    localparam logic [4:0] PFX_T32_A = 5'b11101;
    localparam logic [4:0] PFX_T32_B = 5'b11110;
    localparam logic [4:0] PFX_T32_C = 5'b11111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_32bit_prefix(input logic [15:0] hw);
        return (hw[15:11] == PFX_T32_A) || (hw[15:11] == PFX_T32_B) || (hw[15:11] == PFX_T32_C);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, execute redirect, decoder handoff.
// Latency: none; backpressure: imem_gnt on the memory side, ir_ready on the decoder side.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic [15:0] ir_q0;
    logic [15:0] ir_q1;
    logic        ir_valid;
    logic        ir_is32;
    logic        ir_ready;
    logic [31:0] ir_pc;
    logic        is_thumb;

    modport master (
        output imem_req, imem_addr, ir_q0, ir_q1, ir_valid, ir_is32, ir_pc, is_thumb,
        input  imem_gnt, imem_rvalid, imem_rdata, br_valid, br_target, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_q0, ir_q1, ir_valid, ir_is32, ir_pc, is_thumb,
        output imem_gnt, imem_rvalid, imem_rdata, br_valid, br_target, ir_ready
    );
endinterface

// File: rtl/hw_queue.sv
// 4-entry halfword FIFO, 0/1/2 pushes and pops per cycle, synchronous flush.
// Latency: pushed halfword visible on o_q0 next cycle; no backpressure, the caller never overfills.
module hw_queue import cpu_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic [1:0]        i_push_n,
    input  logic [15:0]       i_push_dat0,
    input  logic [15:0]       i_push_dat1,
    input  logic [1:0]        i_pop_n,
    output logic [QCNT_W-1:0] o_count,
    output logic [15:0]       o_q0,
    output logic [15:0]       o_q1
);
    logic [15:0]       r_mem [QUEUE_DEPTH];
    logic [QPTR_W-1:0] r_rd;
    logic [QPTR_W-1:0] r_wr;
    logic [QCNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push_n != 2'd0) r_mem[r_wr] <= i_push_dat0;
            if (i_push_n == 2'd2) r_mem[r_wr + QPTR_W'(1)] <= i_push_dat1;
            r_wr    <= r_wr + QPTR_W'(i_push_n);
            r_rd    <= r_rd + QPTR_W'(i_pop_n);
            r_count <= r_count + QCNT_W'(i_push_n) - QCNT_W'(i_pop_n);
        end
    end

    assign o_count = r_count;
    assign o_q0    = r_mem[r_rd];
    assign o_q1    = r_mem[r_rd + QPTR_W'(1)];
endmodule

// File: rtl/inst_fetch.sv
// Thumb fetch unit: single-outstanding word fetches into a halfword queue, presents whole instructions.
// Latency: fetched halfword on ir_q0 the cycle after rvalid; stalls fetching when the queue nears full.
module inst_fetch import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    logic [29:0] r_fetch_word;
    logic        r_outstanding;
    logic        r_discard;
    logic        r_skip_lower;
    logic [31:0] r_ir_pc;
    logic        r_is_thumb;

    logic [QCNT_W-1:0] w_count;
    logic [QCNT_W-1:0] w_after_pop;
    logic [15:0]       w_q0;
    logic [15:0]       w_q1;
    logic              w_is32;
    logic              w_valid;
    logic              w_hs;
    logic              w_req;
    logic              w_grant;
    logic              w_resp;
    logic [1:0]        w_pop_n;
    logic [1:0]        w_push_n;
    logic [15:0]       w_push0;
    logic [15:0]       w_push1;

    hw_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.br_valid),
        .i_push_n    (w_push_n),
        .i_push_dat0 (w_push0),
        .i_push_dat1 (w_push1),
        .i_pop_n     (w_pop_n),
        .o_count     (w_count),
        .o_q0        (w_q0),
        .o_q1        (w_q1)
    );

    always_comb begin
        w_is32  = is_32bit_prefix(w_q0);
        w_valid = r_is_thumb && (((w_count >= QCNT_W'(1)) && !w_is32) || (w_count >= QCNT_W'(2)));
        w_hs    = w_valid && bus.ir_ready;
        w_pop_n = 2'd0;
        if (w_hs && !bus.br_valid) w_pop_n = w_is32 ? 2'd2 : 2'd1;
        w_after_pop = w_count - QCNT_W'(w_pop_n);
        w_req   = !rst && !r_outstanding && !bus.br_valid && r_is_thumb && (w_after_pop <= REQ_MAX_FILL);
        w_grant = w_req && bus.imem_gnt;
        // A response only counts against a live request, so rvalids left over from before reset are ignored.
        w_resp  = bus.imem_rvalid && r_outstanding;
        w_push_n = 2'd0;
        w_push0  = bus.imem_rdata[15:0];
        w_push1  = bus.imem_rdata[31:16];
        if (w_resp && !r_discard && !bus.br_valid) begin
            if (r_skip_lower) begin
                w_push_n = 2'd1;
                w_push0  = bus.imem_rdata[31:16];
            end else begin
                w_push_n = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_word  <= RESET_PC[31:2];
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_skip_lower  <= RESET_PC[1];
            r_ir_pc       <= RESET_PC;
            r_is_thumb    <= 1'b1;
        end else if (bus.br_valid) begin
            r_fetch_word  <= bus.br_target[31:2];
            r_ir_pc       <= {bus.br_target[31:1], 1'b0};
            r_is_thumb    <= bus.br_target[0];
            r_skip_lower  <= bus.br_target[1];
            // An in-flight request that has not answered yet belongs to the old stream.
            r_outstanding <= r_outstanding && !w_resp;
            r_discard     <= r_outstanding && !w_resp;
        end else begin
            if (w_grant) begin
                r_fetch_word  <= r_fetch_word + 30'd1;
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
                if (!r_discard) r_skip_lower <= 1'b0;
            end
            if (w_hs) r_ir_pc <= r_ir_pc + (w_is32 ? 32'd4 : 32'd2);
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = {r_fetch_word, 2'b00};
    assign bus.ir_q0     = w_q0;
    assign bus.ir_q1     = w_q1;
    assign bus.ir_valid  = w_valid;
    assign bus.ir_is32   = w_is32;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.is_thumb  = r_is_thumb;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset (halfword aligned).
REQ-002 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: imem_req  out  1  word-fetch request.
REQ-005 Port: imem_addr  out  32  word address of the request; bits [1:0] are always 0.
REQ-006 Port: imem_gnt  in  1  request accepted in the cycle where imem_req and imem_gnt are both 1.
REQ-007 Port: imem_rvalid  in  1  read data valid; asserted 1 or more cycles after the grant.
REQ-008 Port: imem_rdata  in  32  little-endian word; [15:0] is the lower halfword.
REQ-009 Port: br_valid  in  1  redirect pulse from execute.
REQ-010 Port: br_target  in  32  redirect address; bit0 gives the Thumb state, bit1 selects the halfword.
REQ-011 Port: ir_q0  out  16  oldest queued halfword, which is the decoder's first halfword.
REQ-012 Port: ir_q1  out  16  next halfword; meaningful only for 32-bit instructions.
REQ-013 Port: ir_valid  out  1  a complete instruction is presented on ir_q0/ir_q1.
REQ-014 Port: ir_is32  out  1  ir_q0[15:11] is 11101, 11110 or 11111.
REQ-015 Port: ir_ready  in  1  the decoder accepts the presented instruction.
REQ-016 Port: ir_pc  out  32  address of ir_q0.
REQ-017 Port: is_thumb  out  1  Thumb state, forwarded to the decoder's isThumb input.

Function
REQ-018 The block SHALL contain a 4-entry halfword queue, a fetch PC, a single-outstanding-request flag and a discard flag.
REQ-019 ir_valid SHALL be 1 when the queue count is at least 1 and ir_is32 is 0, or when the count is at least 2.
REQ-020 A handshake SHALL be ir_valid and ir_ready both 1; it pops 1 halfword (16-bit instruction) or 2 (32-bit) and advances ir_pc by 2 or 4.
REQ-021 imem_req SHALL be 1 only when there is no outstanding request, no br_valid this cycle, and (count minus this cycle's pops) is 2 or less.
REQ-022 A grant SHALL set the outstanding flag and advance the fetch PC to the next word.
REQ-023 When imem_rvalid is 1 and discard is 0, both halfwords SHALL be pushed (lower first) and the outstanding flag cleared.
REQ-024 Exception to REQ-023: the first response after a redirect with br_target[1]=1 SHALL push only the upper halfword.
REQ-025 A push and a pop in the same cycle SHALL both take effect; the queue SHALL never exceed 4 entries (guaranteed by REQ-021).
REQ-026 br_valid SHALL, in that cycle, empty the queue and load the fetch PC with {br_target[31:2],2'b00}.
REQ-027 br_valid SHALL load ir_pc with {br_target[31:1],1'b0} and is_thumb with br_target[0].
REQ-028 br_valid SHALL set discard if a request is outstanding and has no rvalid in that cycle.
REQ-029 br_valid SHALL take priority over a simultaneous handshake and a simultaneous rvalid; the rvalid data SHALL be dropped.
REQ-030 A response with discard=1 SHALL be dropped, clearing discard and the outstanding flag.
REQ-031 ir_q0, ir_q1 and ir_is32 SHALL be driven from the queue head even when ir_valid=0; the decoder ignores them.
REQ-032 When is_thumb=0, ir_valid SHALL stay 0, with no fetches after the outstanding one resolves, until the next br_valid.
REQ-033 Added latency: a halfword is visible on ir_q0 in the cycle after the rvalid that writes it.

Reset
REQ-034 On rst=1, the queue count, outstanding flag and discard SHALL clear immediately.
REQ-035 On rst=1, the fetch PC SHALL be {RESET_PC[31:2],2'b00} and ir_pc SHALL be RESET_PC.
REQ-036 On rst=1, is_thumb SHALL be 1, imem_req 0, ir_valid 0, and ir_q0/ir_q1 16'h0000.
REQ-037 Reset in the middle of a fetch SHALL abandon the request; an rvalid arriving after reset with no grant since then SHALL be ignored.

Structure
REQ-038 The queue depth, the 32-bit prefix constants (5'b11101, 5'b11110, 5'b11111) and the RESET_PC default SHALL live in shared package cpu_pkg.
REQ-039 The halfword queue SHALL be sub-module hw_queue (push 0/1/2, pop 0/1/2, count, heads q0/q1).
REQ-040 The fetch control SHALL stay in inst_fetch; it SHALL not be a separate state-machine module.

Verification
REQ-041 Reset, gnt=1, 1-cycle rvalid, words 32'h2001_2105 -> ir_q0=16'h2105, then 16'h2001, at ir_pc 0x0, then 0x2.
REQ-042 Word 32'hF800_F000, ready=1 -> one handshake with ir_is32=1, ir_q0=F000, ir_q1=F800, ir_pc advancing by 4.
REQ-043 ready=0 for 10 cycles -> count stays at most 4, imem_req drops, no halfword lost when ready returns.
REQ-044 br_valid with target 0x0000_0103 while a request is outstanding -> stale rvalid dropped, first ir_q0 is the upper halfword of word 0x100, ir_pc=0x102, is_thumb=1.
REQ-045 br_valid and a handshake in the same cycle -> queue empties, ir_pc loads the target, the pop is ignored.
REQ-046 br_target=0x0000_0200 (bit0=0) -> is_thumb=0, ir_valid stays 0, imem_req quiet until the next redirect.
